half_subtractor: RTL and testbench

//   Registered, lane-parallel 1-bit half subtractor: per lane computes a - b

---
 rtl/half_subtractor.sv | 63 ++++++
 tb/tb_half_subtractor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/half_subtractor.sv
// Lane-parallel registered half subtractor with valid qualifier and saturating borrow counter.
module half_subtractor #(
    parameter int WIDTH      = 1,
    parameter bit REGISTERED = 1'b1,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic [WIDTH-1:0] bout,
    output logic             out_valid,
    output logic             bout_any,
    output logic [CNT_W-1:0] borrow_cnt
);
    // purpose: per-lane a-b (diff = a^b, bout = ~a&b), lanes independent, no borrow-in
    // latency: 1 cycle when REGISTERED=1, 0 cycles when REGISTERED=0
    // backpressure: none; each result is shown for one cycle, then overwritten

    logic [WIDTH-1:0] diff_c;
    logic [WIDTH-1:0] bout_c;
    logic             cnt_inc;

    assign diff_c = a ^ b;
    assign bout_c = ~a & b;

    generate
        if (REGISTERED) begin : g_reg
            // Data registers load every cycle; out_valid alone marks a real result.
            always_ff @(posedge clk) begin
                if (rst) begin
                    diff      <= '0;
                    bout      <= '0;
                    out_valid <= 1'b0;
                end else begin
                    diff      <= diff_c;
                    bout      <= bout_c;
                    out_valid <= in_valid;
                end
            end
        end else begin : g_comb
            assign diff      = diff_c;
            assign bout      = bout_c;
            assign out_valid = in_valid;
        end
    endgenerate

    assign bout_any = |bout;

    // out_valid=0 masks any X on the data path so the counter stays clean.
    assign cnt_inc = out_valid & bout_any;

    always_ff @(posedge clk) begin
        if (rst) begin
            borrow_cnt <= '0;
        end else if (cnt_inc && (borrow_cnt != {CNT_W{1'b1}})) begin
            borrow_cnt <= borrow_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_half_subtractor.sv
// Scoreboard bench for half_subtractor: registered WIDTH=1/4 and CNT_W=2 instances, plus a combinational instance.
module tb_half_subtractor;

    logic       clk = 1'b0;
    logic       rst, v1, a1, b1;
    logic [3:0] x4, y4;
    logic       rst0, v0;
    logic [1:0] a0, b0;

    logic       d1_diff, d1_bout, d1_ov, d1_any;
    logic [7:0] d1_cnt;
    logic       d2_diff, d2_bout, d2_ov, d2_any;
    logic [1:0] d2_cnt;
    logic [3:0] d4_diff, d4_bout;
    logic       d4_ov, d4_any;
    logic [7:0] d4_cnt;
    logic [1:0] d0_diff, d0_bout;
    logic       d0_ov, d0_any;
    logic [3:0] d0_cnt;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    half_subtractor #(.WIDTH(1), .REGISTERED(1'b1), .CNT_W(8)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1),
        .diff(d1_diff), .bout(d1_bout), .out_valid(d1_ov), .bout_any(d1_any), .borrow_cnt(d1_cnt));

    half_subtractor #(.WIDTH(1), .REGISTERED(1'b1), .CNT_W(2)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1),
        .diff(d2_diff), .bout(d2_bout), .out_valid(d2_ov), .bout_any(d2_any), .borrow_cnt(d2_cnt));

    half_subtractor #(.WIDTH(4), .REGISTERED(1'b1), .CNT_W(8)) u_d4 (
        .clk(clk), .rst(rst), .in_valid(v1), .a(x4), .b(y4),
        .diff(d4_diff), .bout(d4_bout), .out_valid(d4_ov), .bout_any(d4_any), .borrow_cnt(d4_cnt));

    half_subtractor #(.WIDTH(2), .REGISTERED(1'b0), .CNT_W(4)) u_d0 (
        .clk(clk), .rst(rst0), .in_valid(v0), .a(a0), .b(b0),
        .diff(d0_diff), .bout(d0_bout), .out_valid(d0_ov), .bout_any(d0_any), .borrow_cnt(d0_cnt));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference truth table, lane by lane: returns {diff[3:0], bout[3:0]}.
    function automatic logic [7:0] hs_ref(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] d, bo;
        for (int i = 0; i < 4; i++) begin
            case ({x[i], y[i]})
                2'b00:   begin d[i] = 1'b0; bo[i] = 1'b0; end
                2'b01:   begin d[i] = 1'b1; bo[i] = 1'b1; end
                2'b10:   begin d[i] = 1'b1; bo[i] = 1'b0; end
                default: begin d[i] = 1'b0; bo[i] = 1'b0; end
            endcase
        end
        return {d, bo};
    endfunction

    typedef struct {
        logic       rst;
        logic       ov;
        logic       d1;
        logic       b1;
        logic [3:0] d4;
        logic [3:0] b4;
    } exp_t;

    exp_t sb[$];

    int   c1, c2, c4;
    logic p1 = 1'b0;
    logic p4 = 1'b0;

    // Drive one cycle of stimulus on the registered instances, push the
    // expected result, then pop and compare it once the DUT presents it.
    task automatic step(input logic r, input logic v, input logic a, input logic b,
                        input logic [3:0] x, input logic [3:0] y);
        exp_t       e, o;
        logic [7:0] t1, t4;
        rst = r; v1 = v; a1 = a; b1 = b; x4 = x; y4 = y;
        t1 = hs_ref({3'b000, a}, {3'b000, b});
        t4 = hs_ref(x, y);
        e.rst = r;
        e.ov  = v & ~r;
        e.d1  = r ? 1'b0 : t1[4];
        e.b1  = r ? 1'b0 : t1[0];
        e.d4  = r ? 4'h0 : t4[7:4];
        e.b4  = r ? 4'h0 : t4[3:0];
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_eq("sb_empty", 32'd0, 32'd1);
            return;
        end
        o = sb.pop_front();
        if (o.rst) begin
            c1 = 0; c2 = 0; c4 = 0;
        end else begin
            if (p1 && c1 != 255) c1++;
            if (p1 && c2 != 3)   c2++;
            if (p4 && c4 != 255) c4++;
        end
        p1 = o.rst ? 1'b0 : (o.ov & o.b1);
        p4 = o.rst ? 1'b0 : (o.ov & (|o.b4));
        check_eq("d1_diff", d1_diff, o.d1);
        check_eq("d1_bout", d1_bout, o.b1);
        check_eq("d1_ov",   d1_ov,   o.ov);
        check_eq("d1_any",  d1_any,  o.b1);
        check_eq("d1_cnt",  d1_cnt,  c1);
        check_eq("d2_ov",   d2_ov,   o.ov);
        check_eq("d2_cnt",  d2_cnt,  c2);
        check_eq("d4_diff", d4_diff, o.d4);
        check_eq("d4_bout", d4_bout, o.b4);
        check_eq("d4_ov",   d4_ov,   o.ov);
        check_eq("d4_any",  d4_any,  |o.b4);
        check_eq("d4_cnt",  d4_cnt,  c4);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] t;
        int         c0;
        logic [1:0] sd, sb0;
        rst = 1'b1; v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; x4 = 4'h0; y4 = 4'h0;
        rst0 = 1'b1; v0 = 1'b0; a0 = 2'b00; b0 = 2'b00;

        // Reset state
        step(1, 0, 0, 0, 4'h0, 4'h0);
        step(1, 0, 0, 0, 4'h0, 4'h0);
        check_eq("rst_cnt", d1_cnt, 32'd0);

        // Truth table, back-to-back valid
        step(0, 1, 0, 0, 4'h3, 4'h5);
        step(0, 1, 0, 1, 4'hA, 4'h6);
        step(0, 1, 1, 0, 4'hF, 4'h0);
        step(0, 1, 1, 1, 4'h0, 4'hF);

        // Reset asserted for two cycles while traffic continues
        step(1, 1, 0, 1, 4'h0, 4'hF);
        step(1, 1, 0, 1, 4'h1, 4'hE);
        check_eq("rst_mid_ov", d1_ov, 32'd0);
        step(0, 0, 1, 0, 4'h2, 4'h2);
        step(0, 1, 0, 1, 4'h0, 4'h1);

        // Counter: 5 borrows, 3 non-borrows, then one borrow more
        step(1, 0, 0, 0, 4'h0, 4'h0);
        repeat (5) step(0, 1, 0, 1, 4'h0, 4'h1);
        repeat (3) step(0, 1, 1, 0, 4'h1, 4'h0);
        step(0, 0, 0, 0, 4'h0, 4'h0);
        check_eq("cnt_five", d1_cnt, 32'd5);
        check_eq("cnt_sat3", d2_cnt, 32'd3);
        step(0, 1, 0, 1, 4'h0, 4'h1);
        step(0, 0, 0, 0, 4'h0, 4'h0);
        check_eq("cnt_six",   d1_cnt, 32'd6);
        check_eq("cnt_hold3", d2_cnt, 32'd3);

        // in_valid=0 with a borrow pattern must not count
        step(0, 0, 0, 1, 4'h0, 4'hF);
        step(0, 0, 0, 0, 4'h0, 4'h0);
        check_eq("inv_cnt", d1_cnt, 32'd6);

        // Four lanes, explicit pattern
        step(0, 1, 0, 0, 4'b0101, 4'b0011);
        check_eq("w4_diff", d4_diff, 32'b0110);
        check_eq("w4_bout", d4_bout, 32'b0010);
        check_eq("w4_any",  d4_any,  32'd1);

        // Random traffic with occasional reset
        for (int i = 0; i < 40; i++) begin
            step(($urandom_range(15) == 0), $urandom_range(1), $urandom_range(1), $urandom_range(1),
                 4'($urandom_range(15)), 4'($urandom_range(15)));
        end

        // Combinational instance: exhaustive 2-bit sweep
        @(posedge clk); #1;
        rst0 = 1'b0;
        c0 = 0;
        for (int i = 0; i < 16; i++) begin
            a0 = 2'(i >> 2); b0 = 2'(i); v0 = 1'b1;
            t   = hs_ref({2'b00, a0}, {2'b00, b0});
            sd  = t[5:4];
            sb0 = t[1:0];
            #1;
            check_eq("c_diff", d0_diff, sd);
            check_eq("c_bout", d0_bout, sb0);
            check_eq("c_ov",   d0_ov,   32'd1);
            check_eq("c_any",  d0_any,  |sb0);
            rst0 = 1'b1;
            #1;
            check_eq("c_rst_diff", d0_diff, sd);
            check_eq("c_rst_bout", d0_bout, sb0);
            rst0 = 1'b0;
            @(posedge clk); #1;
            if (|sb0) c0++;
            check_eq("c_cnt", d0_cnt, c0);
        end
        check_eq("c_cnt_total", d0_cnt, 32'd7);

        v0 = 1'b0; a0 = 2'b00; b0 = 2'b11;
        #1;
        check_eq("c_inv_ov", d0_ov, 32'd0);
        @(posedge clk); #1;
        check_eq("c_inv_cnt", d0_cnt, 32'd7);

        v0 = 1'b0; a0 = 2'bxx; b0 = 2'bxx;
        @(posedge clk); #1;
        check_eq("c_x_cnt", d0_cnt, 32'd7);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
